// File: rtl/axis_video_frame_checker_if.sv
// AXI4-Stream video bus between a pixel source and the frame checker.
// tuser marks the first pixel of a frame, tlast the last pixel of a line.
interface axis_video_frame_checker_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_video_frame_checker.sv
// AXI4-Stream video sink: measures frame geometry, flags line-length and early-SOF
// errors and accumulates a per-frame pixel checksum for a register block.
module axis_video_frame_checker #(
    parameter int DATA_W     = 24,
    parameter int EXP_WIDTH  = 640,
    parameter int EXP_HEIGHT = 480,
    parameter int CNT_W      = 12
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        enable,
    axis_video_frame_checker_if.slave   s_axis_video,
    output logic                        frame_done,
    output logic [CNT_W-1:0]            meas_width,
    output logic [CNT_W-1:0]            meas_height,
    output logic [2:0]                  frame_status,
    output logic [31:0]                 frame_sum,
    output logic [15:0]                 frame_cnt,
    output logic [15:0]                 bad_frame_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        ACTIVE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] EXP_W_C  = CNT_W'(EXP_WIDTH);
    localparam logic [CNT_W-1:0] EXP_H_C  = CNT_W'(EXP_HEIGHT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    state_t            state_r;
    logic              tready_r;
    logic [CNT_W-1:0]  pix_cnt_r;
    logic [CNT_W-1:0]  line_cnt_r;
    logic [CNT_W-1:0]  width_r;
    logic [31:0]       sum_r;
    logic              short_r;
    logic              long_r;

    logic              frame_done_r;
    logic [CNT_W-1:0]  meas_width_r;
    logic [CNT_W-1:0]  meas_height_r;
    logic [2:0]        frame_status_r;
    logic [31:0]       frame_sum_r;
    logic [15:0]       frame_cnt_r;
    logic [15:0]       bad_frame_cnt_r;

    logic [DATA_W-1:0] tdata_s;
    logic              beat_s;
    logic              take_s;
    logic              sof_s;
    logic              early_close_s;
    logic [CNT_W-1:0]  base_pix_s;
    logic [CNT_W-1:0]  base_line_s;
    logic [CNT_W-1:0]  base_width_s;
    logic [31:0]       base_sum_s;
    logic              base_short_s;
    logic              base_long_s;
    logic [CNT_W-1:0]  cnt_s;
    logic [31:0]       sum_add_s;

    state_t            nxt_state_s;
    logic [CNT_W-1:0]  nxt_pix_s;
    logic [CNT_W-1:0]  nxt_line_s;
    logic [CNT_W-1:0]  nxt_width_s;
    logic [31:0]       nxt_sum_s;
    logic              nxt_short_s;
    logic              nxt_long_s;
    logic              line_close_s;
    logic              close_s;
    logic [CNT_W-1:0]  close_width_s;
    logic [CNT_W-1:0]  close_height_s;
    logic [2:0]        close_status_s;
    logic [31:0]       close_sum_s;

    assign tdata_s = s_axis_video.tdata;
    assign beat_s  = s_axis_video.tvalid & tready_r;
    // WAIT_SOF only accepts a beat carrying tuser; everything else there is discarded.
    assign take_s  = beat_s & ((state_r == ACTIVE) | ((state_r == WAIT_SOF) & s_axis_video.tuser));
    assign sof_s   = take_s & s_axis_video.tuser;
    assign early_close_s = sof_s & (state_r == ACTIVE);

    // A SOF beat restarts accumulation from zero before its own pixel is counted.
    assign base_pix_s   = sof_s ? CNT_ZERO : pix_cnt_r;
    assign base_line_s  = sof_s ? CNT_ZERO : line_cnt_r;
    assign base_width_s = sof_s ? CNT_ZERO : width_r;
    assign base_sum_s   = sof_s ? 32'd0 : sum_r;
    assign base_short_s = sof_s ? 1'b0 : short_r;
    assign base_long_s  = sof_s ? 1'b0 : long_r;
    assign cnt_s        = sat_inc(base_pix_s);
    assign sum_add_s    = base_sum_s + 32'(tdata_s);

    // Per-beat next values for the running frame, including line-end handling.
    always_comb begin
        nxt_state_s  = state_r;
        nxt_pix_s    = pix_cnt_r;
        nxt_line_s   = line_cnt_r;
        nxt_width_s  = width_r;
        nxt_sum_s    = sum_r;
        nxt_short_s  = short_r;
        nxt_long_s   = long_r;
        line_close_s = 1'b0;
        if (take_s) begin
            nxt_state_s = ACTIVE;
            nxt_sum_s   = sum_add_s;
            if (s_axis_video.tlast) begin
                nxt_short_s = base_short_s | (cnt_s < EXP_W_C);
                nxt_long_s  = base_long_s | (cnt_s > EXP_W_C);
                nxt_width_s = (base_line_s == CNT_ZERO) ? cnt_s : base_width_s;
                nxt_pix_s   = CNT_ZERO;
                nxt_line_s  = sat_inc(base_line_s);
                if (nxt_line_s == EXP_H_C) begin
                    line_close_s = 1'b1;
                    nxt_state_s  = WAIT_SOF;
                end else begin
                    line_close_s = 1'b0;
                end
            end else begin
                nxt_short_s = base_short_s;
                // Reaching the expected width without tlast means the line is already too long.
                nxt_long_s  = base_long_s | (cnt_s >= EXP_W_C);
                nxt_width_s = base_width_s;
                nxt_pix_s   = cnt_s;
                nxt_line_s  = base_line_s;
            end
        end else begin
            nxt_state_s = state_r;
        end
    end

    // Select what gets published when a frame closes (normal end or early SOF).
    always_comb begin
        close_s = line_close_s | early_close_s;
        if (line_close_s) begin
            close_width_s  = nxt_width_s;
            close_height_s = nxt_line_s;
            close_status_s = {1'b0, nxt_long_s, nxt_short_s};
            close_sum_s    = nxt_sum_s;
        end else begin
            close_width_s  = width_r;
            close_height_s = line_cnt_r;
            close_status_s = {1'b1, long_r, short_r};
            close_sum_s    = sum_r;
        end
    end

    // FSM, frame accumulators and registered status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r         <= IDLE;
            tready_r        <= 1'b0;
            pix_cnt_r       <= CNT_ZERO;
            line_cnt_r      <= CNT_ZERO;
            width_r         <= CNT_ZERO;
            sum_r           <= 32'd0;
            short_r         <= 1'b0;
            long_r          <= 1'b0;
            frame_done_r    <= 1'b0;
            meas_width_r    <= CNT_ZERO;
            meas_height_r   <= CNT_ZERO;
            frame_status_r  <= 3'b000;
            frame_sum_r     <= 32'd0;
            frame_cnt_r     <= 16'd0;
            bad_frame_cnt_r <= 16'd0;
        end else begin
            tready_r     <= enable;
            frame_done_r <= 1'b0;
            if (!enable || (state_r == IDLE)) begin
                state_r    <= enable ? WAIT_SOF : IDLE;
                pix_cnt_r  <= CNT_ZERO;
                line_cnt_r <= CNT_ZERO;
                width_r    <= CNT_ZERO;
                sum_r      <= 32'd0;
                short_r    <= 1'b0;
                long_r     <= 1'b0;
            end else begin
                case (state_r)
                    WAIT_SOF, ACTIVE: begin
                        state_r    <= nxt_state_s;
                        pix_cnt_r  <= nxt_pix_s;
                        line_cnt_r <= nxt_line_s;
                        width_r    <= nxt_width_s;
                        sum_r      <= nxt_sum_s;
                        short_r    <= nxt_short_s;
                        long_r     <= nxt_long_s;
                        if (close_s) begin
                            frame_done_r   <= 1'b1;
                            meas_width_r   <= close_width_s;
                            meas_height_r  <= close_height_s;
                            frame_status_r <= close_status_s;
                            frame_sum_r    <= close_sum_s;
                            frame_cnt_r    <= frame_cnt_r + 16'd1;
                            if ((close_status_s != 3'b000) && (bad_frame_cnt_r != 16'hFFFF)) begin
                                bad_frame_cnt_r <= bad_frame_cnt_r + 16'd1;
                            end else begin
                                bad_frame_cnt_r <= bad_frame_cnt_r;
                            end
                        end else begin
                            frame_done_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign s_axis_video.tready = tready_r;
    assign frame_done          = frame_done_r;
    assign meas_width          = meas_width_r;
    assign meas_height         = meas_height_r;
    assign frame_status        = frame_status_r;
    assign frame_sum           = frame_sum_r;
    assign frame_cnt           = frame_cnt_r;
    assign bad_frame_cnt       = bad_frame_cnt_r;

endmodule

// File: doc/axis_video_frame_checker.md
Name: axis_video_frame_checker

Overview:
- AXI4-Stream video sink and checker. It consumes a video stream and measures frame geometry (pixels per line, lines per frame).
- It flags line-length and start-of-frame protocol errors and accumulates a per-frame pixel checksum.
- It is the receiving end for the synthetic and camera AXI video sources (SyntPic / MyYCbCr outputs).
- It terminates the stream in bring-up builds and exposes status for a CPU/APB register block.

Parameters:
DATA_W, 24, width of s_axis_video_tdata
EXP_WIDTH, 640, expected pixels per line
EXP_HEIGHT, 480, expected lines per frame
CNT_W, 12, width of pixel/line counters and measured geometry outputs

Ports:
clk  in  1  system clock
rstn  in  1  reset (asynchronous, active-low)
enable  in  1  checker enable; low = stream not accepted, checker idle
s_axis_video_tdata  in  DATA_W  pixel data
s_axis_video_tvalid  in  1  pixel valid
s_axis_video_tready  out  1  sink ready
s_axis_video_tuser  in  1  start of frame (first pixel of frame)
s_axis_video_tlast  in  1  end of line (last pixel of line)
frame_done  out  1  one-cycle pulse, frame closed; status outputs updated same cycle
meas_width  out  CNT_W  pixel count of first line of last closed frame
meas_height  out  CNT_W  line count of last closed frame
frame_status  out  3  bit0 short line, bit1 long line, bit2 early SOF (last closed frame)
frame_sum  out  32  modulo-2^32 sum of zero-extended tdata over last closed frame
frame_cnt  out  16  frames closed since reset, wraps
bad_frame_cnt  out  16  frames closed with nonzero status, saturates at 16'hFFFF

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters and sticky flags 0.
- tready is registered: tready <= enable. Beat = tvalid & tready. Only beats change state or counters.
- FSM states:
  - IDLE: entered whenever enable=0; clears pix_cnt, line_cnt, running sum and flags; next cycle with enable=1 -> WAIT_SOF.
  - WAIT_SOF: beats without tuser are discarded and change nothing. Beat with tuser -> ACTIVE with pix_cnt=1, line_cnt=0, sum=tdata, flags=0.
  - ACTIVE: each beat adds 1 to pix_cnt and adds tdata to sum.
- tlast beat in ACTIVE (this beat included in the line count; its pixel count = pix_cnt+1):
  - If count < EXP_WIDTH: set short flag. If count > EXP_WIDTH: set long flag.
  - First line of the frame: latch count into width register.
  - pix_cnt <= 0; line_cnt <= line_cnt+1.
  - If line_cnt+1 == EXP_HEIGHT: close the frame and go to WAIT_SOF.
- Long line without tlast: when pix_cnt reaches EXP_WIDTH and the current beat has no tlast, set long flag immediately. Counting continues, saturating at 2^CNT_W-1.
- tuser beat in ACTIVE (early SOF):
  - Close the current frame with bit2 set; meas_height = lines completed.
  - Start a new frame on this same beat (pix_cnt=1, sum=tdata, flags cleared); stay ACTIVE.
- tuser and tlast on the same beat:
  - tuser handled first (frame start or early SOF).
  - tlast then ends a 1-pixel line in the new frame; short flag set if EXP_WIDTH>1.
- Close frame:
  - Registered outputs update, and frame_done is high, in the cycle after the closing beat (latency 1).
  - frame_cnt increments; bad_frame_cnt increments if status != 0.
  - Status, width and sum reflect all beats up to and including the closing tlast. For an early-SOF close, the triggering beat is excluded and belongs to the new frame.
- Dropping enable mid-frame: go to IDLE on the next clock; no frame_done; last-frame outputs keep their values.
- Async reset mid-frame: everything returns to reset values at once.
- Sum arithmetic: 32-bit, wraps; tdata zero-extended.

Test Plan (EXP_WIDTH=8, EXP_HEIGHT=4, DATA_W=24 unless stated):
1. Nominal frame, tdata = beat index 0..31, tuser on beat 0, tlast every 8th beat -> one frame_done, meas_width=8, meas_height=4, frame_status=0, frame_sum=496, frame_cnt=1, bad_frame_cnt=0.
2. Same as 1 with tvalid toggling 4-on/3-off and enable held -> identical results; frame_done exactly 1 cycle after final tlast beat.
3. Line 2 has tlast on 6th beat, line 3 has tlast on 10th beat -> frame_status=3'b011, meas_width=8, meas_height=4, bad_frame_cnt=1.
4. tuser reasserted after 2 complete lines + 3 pixels -> frame_done with frame_status=3'b100, meas_height=2. A following clean frame -> frame_status=0, frame_cnt=2.
5. 5 beats without tuser before first SOF -> ignored; first frame still gives meas_width=8, frame_sum equals sum of post-SOF data only.
6. enable dropped after 10 beats, re-raised, full frame sent -> no frame_done for partial frame; tready low one cycle after enable falls; frame_cnt=1 after full frame.
